// File: rtl/pam_tx_pkg.sv
// Shared types and helpers for the PAM transmit path: FSM state encoding,
// Gray-to-binary conversion and PAM level computation.
package pam_tx_pkg;

  typedef enum logic {
    PREAMBLE = 1'b0,
    DATA     = 1'b1
  } state_t;

  // Symbol words are at most 4 bits wide; narrower words arrive zero-extended,
  // which leaves the conversion of the live bits unchanged.
  function automatic logic [3:0] gray2bin(input logic [3:0] g);
    logic [3:0] b;
    b[3] = g[3];
    for (int i = 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  function automatic int pam_level(input int k, input int m, input int amplitude);
    return (2 * k - (m - 1)) * amplitude;
  endfunction

endpackage

// File: rtl/pam_gray_mapper.sv
// Combinational Gray-coded symbol word to signed PAM-M amplitude mapper.
// Kept standalone so the QAM transmitter can reuse it per rail.
module pam_gray_mapper
  import pam_tx_pkg::*;
#(
  parameter int BitsPerSymbol    = 2,
  parameter int Amplitude        = 256,
  parameter int OutputLengthBits = 12
) (
  input  logic        [BitsPerSymbol-1:0]    sym_i,
  output logic signed [OutputLengthBits-1:0] level_o
);

  localparam int M = 2 ** BitsPerSymbol;

  logic [3:0] binIdx;
  int         levelInt;

  always_comb begin
    binIdx   = gray2bin(4'(sym_i));
    levelInt = pam_level(int'(binIdx), M, Amplitude);
    level_o  = OutputLengthBits'(levelInt);
  end

endmodule

// File: rtl/pam_symbol_upsampler.sv
// PAM symbol source: Gray-maps input symbols and zero-stuffs them to
// SamplesPerSymbol output samples. Optional preamble via PAM_TX_PREAMBLE_EN.
module pam_symbol_upsampler
  import pam_tx_pkg::*;
#(
  parameter int SamplesPerSymbol = 4,
  parameter int BitsPerSymbol    = 2,
  parameter int Amplitude        = 256,
  parameter int OutputLengthBits = 12,
  parameter int PreambleSymbols  = 32
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic        [BitsPerSymbol-1:0]    in,
  input  logic                               in_valid,
  output logic                               in_ready,
  output logic signed [OutputLengthBits-1:0] out,
  output logic                               out_valid,
  input  logic                               out_ready,
  output logic                               symbol_strobe
);

  localparam int M        = 2 ** BitsPerSymbol;
  localparam int MaxLevel = (M - 1) * Amplitude;
  localparam int MaxRep   = 2 ** (OutputLengthBits - 1) - 1;
  localparam int PhaseW   = (SamplesPerSymbol > 2) ? $clog2(SamplesPerSymbol) : 1;

  typedef logic [PhaseW-1:0] phase_t;
  typedef logic signed [OutputLengthBits-1:0] sample_t;

  localparam phase_t LastPhase = phase_t'(SamplesPerSymbol - 1);

  if (SamplesPerSymbol < 2 || (SamplesPerSymbol % 2) != 0) begin : gBadSps
    $error("SamplesPerSymbol must be even and >= 2");
  end
  if (BitsPerSymbol < 1 || BitsPerSymbol > 4) begin : gBadBps
    $error("BitsPerSymbol must be in 1..4");
  end
  if (MaxLevel > MaxRep) begin : gBadWidth
    $error("OutputLengthBits too narrow for (M-1)*Amplitude");
  end
  if (PreambleSymbols < 1) begin : gBadPre
    $error("PreambleSymbols must be >= 1");
  end

  sample_t out_q, out_d;
  logic    outValid_q, outValid_d;
  logic    strobe_q, strobe_d;
  phase_t  phase_q, phase_d;

  sample_t dataLevel;
  logic    lastSample, consume, slotFree, accept;
  logic    inData, preLoad;
  sample_t preLevel;

  pam_gray_mapper #(
    .BitsPerSymbol   (BitsPerSymbol),
    .Amplitude       (Amplitude),
    .OutputLengthBits(OutputLengthBits)
  ) uMapper (
    .sym_i  (in),
    .level_o(dataLevel)
  );

  assign lastSample = (phase_q == LastPhase);
  assign consume    = outValid_q && out_ready;
  // The output register can take a new symbol when empty or when its last
  // sample leaves this cycle; there is deliberately no skid buffer.
  assign slotFree   = !outValid_q || (consume && lastSample);
  assign in_ready   = inData && slotFree;
  assign accept     = in_valid && in_ready;

`ifdef PAM_TX_PREAMBLE_EN
  localparam int PreW = (PreambleSymbols > 1) ? $clog2(PreambleSymbols) : 1;

  state_t          state_q, state_d;
  logic [PreW-1:0] preCnt_q, preCnt_d;
  logic            symDone, preLastSym, preNeg;

  assign symDone    = consume && lastSample;
  assign preLastSym = (preCnt_q == PreW'(PreambleSymbols - 1));
  assign inData     = (state_q == DATA);
  assign preLoad    = (state_q == PREAMBLE) && slotFree && !(symDone && preLastSym);
  // The counter lags by one symbol when the next one loads on a consume edge.
  assign preNeg     = preCnt_q[0] ^ symDone;
  assign preLevel   = preNeg ? sample_t'(-MaxLevel) : sample_t'(MaxLevel);

  always_comb begin
    state_d  = state_q;
    preCnt_d = preCnt_q;
    if (state_q == PREAMBLE && symDone) begin
      if (preLastSym) begin
        state_d = DATA;
      end else begin
        preCnt_d = preCnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= PREAMBLE;
      preCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      preCnt_q <= preCnt_d;
    end
  end
`else
  assign inData   = 1'b1;
  assign preLoad  = 1'b0;
  assign preLevel = '0;
`endif

  always_comb begin
    out_d      = out_q;
    outValid_d = outValid_q;
    strobe_d   = strobe_q;
    phase_d    = phase_q;
    if (accept || preLoad) begin
      out_d      = accept ? dataLevel : preLevel;
      outValid_d = 1'b1;
      strobe_d   = 1'b1;
      phase_d    = '0;
    end else if (consume) begin
      out_d    = '0;
      strobe_d = 1'b0;
      if (lastSample) begin
        outValid_d = 1'b0;
        phase_d    = '0;
      end else begin
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_q      <= '0;
      outValid_q <= 1'b0;
      strobe_q   <= 1'b0;
      phase_q    <= '0;
    end else begin
      out_q      <= out_d;
      outValid_q <= outValid_d;
      strobe_q   <= strobe_d;
      phase_q    <= phase_d;
    end
  end

  assign out           = out_q;
  assign out_valid     = outValid_q;
  assign symbol_strobe = strobe_q;

endmodule

// File: tb/tb_pam_symbol_upsampler.sv
// Scoreboard bench for pam_symbol_upsampler with SPS=4, 2 bits/symbol, A=1.
// Preamble expectations are included when PAM_TX_PREAMBLE_EN is defined.
module tb_pam_symbol_upsampler;

  localparam int SPS = 4;
  localparam int BPS = 2;
  localparam int OLB = 12;
  localparam int PRE = 4;

  typedef struct {
    int   val;
    logic strobe;
  } sample_t;

  logic                  clk = 1'b0;
  logic                  rst = 1'b0;
  logic [BPS-1:0]        in = '0;
  logic                  in_valid = 1'b0;
  logic                  in_ready;
  logic signed [OLB-1:0] out;
  logic                  out_valid;
  logic                  out_ready = 1'b0;
  logic                  symbol_strobe;

  sample_t q[$];
  int      total = 0;
  int      bad = 0;
  int      preToLoad = 0;
  int      preSamplesLeft = 0;
  int      preIdx = 0;
  int      acceptCount = 0;

  pam_symbol_upsampler #(
    .SamplesPerSymbol(SPS),
    .BitsPerSymbol   (BPS),
    .Amplitude       (1),
    .OutputLengthBits(OLB),
    .PreambleSymbols (PRE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .in           (in),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .out          (out),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .symbol_strobe(symbol_strobe)
  );

  always #5 clk = ~clk;

  function automatic int grayLevel(input logic [1:0] s);
    case (s)
      2'b00:   return -3;
      2'b01:   return -1;
      2'b11:   return 1;
      default: return 3;
    endcase
  endfunction

  task automatic checkOutput(input string tag, input int observed, input int expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", tag, observed, expected, $time);
    end
  endtask

  task automatic pushSymbol(input int level);
    sample_t s;
    for (int i = 0; i < SPS; i++) begin
      s.val    = (i == 0) ? level : 0;
      s.strobe = (i == 0);
      q.push_back(s);
    end
  endtask

  // One clock cycle: drive at the falling edge, check just after, update model.
  task automatic applyStimulus(input logic iv, input logic [1:0] sym, input logic ordy);
    sample_t e;
    logic    expIr, consume, free;
    @(negedge clk);
    in_valid  = iv;
    in        = sym;
    out_ready = ordy;
    #1;
    expIr = (preSamplesLeft == 0) && (q.size() == 0 || (ordy && q.size() == 1));
    checkOutput("out_valid", int'(out_valid), int'(q.size() != 0));
    checkOutput("in_ready", int'(in_ready), int'(expIr));
    consume = (q.size() != 0) && ordy;
    if (q.size() != 0) begin
      e = q[0];
      checkOutput("out", int'(out), e.val);
      checkOutput("strobe", int'(symbol_strobe), int'(e.strobe));
    end else begin
      checkOutput("out_idle", int'(out), 0);
      checkOutput("strobe_idle", int'(symbol_strobe), 0);
    end
    if (consume) begin
      void'(q.pop_front());
      if (preSamplesLeft > 0) preSamplesLeft--;
    end
    free = (q.size() == 0);
    if (free && preToLoad > 0) begin
      pushSymbol((preIdx % 2 == 0) ? 3 : -3);
      preIdx++;
      preToLoad--;
    end else if (iv && in_ready) begin
      acceptCount++;
      pushSymbol(grayLevel(sym));
    end
  endtask

  task automatic doReset();
    @(negedge clk);
    in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    checkOutput("rst_out_valid", int'(out_valid), 0);
    checkOutput("rst_out", int'(out), 0);
    checkOutput("rst_strobe", int'(symbol_strobe), 0);
    q.delete();
`ifdef PAM_TX_PREAMBLE_EN
    preToLoad      = PRE;
    preSamplesLeft = PRE * SPS;
    preIdx         = 0;
`endif
    @(posedge clk);
    #2 rst = 1'b0;
  endtask

  task automatic idle(input int n, input logic ordy);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 2'b00, ordy);
  endtask

  initial begin
    logic [1:0] pattern [4];
    pattern[0] = 2'b00;
    pattern[1] = 2'b01;
    pattern[2] = 2'b11;
    pattern[3] = 2'b10;

    doReset();
`ifdef PAM_TX_PREAMBLE_EN
    // Preamble: in_valid held high yet nothing is accepted until it drains.
    for (int i = 0; i < PRE * SPS + 1; i++) applyStimulus(1'b1, 2'b11, 1'b1);
    idle(SPS + 1, 1'b1);
`endif

    // Mapping stream, one symbol per 4 samples.
    for (int s = 0; s < 4; s++) begin
      applyStimulus(1'b1, pattern[s], 1'b1);
      for (int i = 0; i < SPS - 1; i++) applyStimulus(1'b0, 2'b00, 1'b1);
    end
    idle(SPS + 1, 1'b1);

    // Backpressure at phase 2 with a symbol waiting.
    applyStimulus(1'b1, 2'b10, 1'b1);
    applyStimulus(1'b1, 2'b01, 1'b1);
    applyStimulus(1'b1, 2'b01, 1'b1);
    for (int i = 0; i < 5; i++) applyStimulus(1'b1, 2'b01, 1'b0);
    idle(2 * SPS + 1, 1'b1);

    // Underrun after a single symbol, then restart.
    applyStimulus(1'b1, 2'b11, 1'b1);
    idle(SPS + 3, 1'b1);
    applyStimulus(1'b1, 2'b00, 1'b1);
    idle(SPS + 1, 1'b1);

    // Back-to-back: in_valid held for three symbols.
    acceptCount = 0;
    for (int i = 0; i < 3 * SPS; i++) applyStimulus(1'b1, pattern[(i / SPS) % 4], 1'b1);
    checkOutput("b2b_accepts", acceptCount, 3);
    idle(2 * SPS, 1'b1);

    // Async reset during phase 1.
    applyStimulus(1'b1, 2'b10, 1'b1);
    applyStimulus(1'b0, 2'b00, 1'b1);
    doReset();
`ifdef PAM_TX_PREAMBLE_EN
    for (int i = 0; i < PRE * SPS + 1; i++) applyStimulus(1'b0, 2'b00, 1'b1);
`endif
    applyStimulus(1'b1, 2'b01, 1'b1);
    idle(SPS + 1, 1'b1);

    // Random traffic on both handshakes.
    for (int i = 0; i < 120; i++) begin
      applyStimulus(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                    1'($urandom_range(0, 3) != 0));
    end
    idle(3 * SPS, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
